// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end of the CPU core.
//   state_e       : fetch-sequencer FSM encoding (S_FETCH / S_EXEC)
//   WORD_BYTES    : bytes per instruction word, the sequential PC step
//   OFFSET_W_DEF  : default width of the signed word offset
//   RESET_PC_DEF  : default PC loaded on reset
package cpu_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_e;

    localparam int          WORD_BYTES   = 4;
    localparam int          OFFSET_W_DEF = 8;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC arithmetic: sequential address and branch/jump target, then select.
// Purely combinational; all sums are modulo 2^32.
//   pc_i       : address of the current instruction
//   offset_i   : signed word offset taken from the instruction
//   redirect_i : 1 = take the target (jump or taken branch)
//   next_pc_o  : address of the next instruction
module pc_target_calc
    import cpu_pkg::*;
#(
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic [31:0]         pc_i,
    input  logic [OFFSET_W-1:0] offset_i,
    input  logic                redirect_i,
    output logic [31:0]         next_pc_o
);

    logic [31:0] seq_pc;
    logic [31:0] offset_ext;
    logic [31:0] tgt_pc;

    assign seq_pc     = pc_i + 32'(WORD_BYTES);
    // Sign-extend the word offset to 32 bits, then scale words to bytes.
    assign offset_ext = {{(32 - OFFSET_W){offset_i[OFFSET_W-1]}}, offset_i};
    assign tgt_pc     = seq_pc + (offset_ext << 2);
    assign next_pc_o  = redirect_i ? tgt_pc : seq_pc;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction fetch sequencer.
// Alternates S_FETCH (read instruction memory at PC) and S_EXEC (hold the
// latched instruction for the core, then advance PC on the retiring edge).
//   CLK, RESET            : clock, asynchronous active-high reset
//   STALL                 : freezes S_EXEC while the core is busy
//   JUMP, BRANCH_TAKEN    : redirect requests, sampled on the retiring edge
//   OFFSET                : signed word offset for the redirect target
//   IMEM_READDATA/BUSYWAIT: instruction memory response
//   IMEM_READ/ADDRESS     : instruction memory request (address = PC)
//   PC, INSTRUCTION       : current instruction address and word
//   INSTR_VALID           : 1 while INSTRUCTION is executing
//   INSTR_COUNT           : instructions retired since reset
//   DBG_STATE             : current FSM state, for observation only
// Handshake: a read is requested whenever IMEM_READ=1; the word is accepted
// on the first rising edge where IMEM_BUSYWAIT=0, and never while it is 1.
module pc_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          OFFSET_W = OFFSET_W_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                STALL,
    input  logic                JUMP,
    input  logic                BRANCH_TAKEN,
    input  logic [OFFSET_W-1:0] OFFSET,
    input  logic [31:0]         IMEM_READDATA,
    input  logic                IMEM_BUSYWAIT,
    output logic                IMEM_READ,
    output logic [31:0]         IMEM_ADDRESS,
    output logic [31:0]         PC,
    output logic [31:0]         INSTRUCTION,
    output logic                INSTR_VALID,
    output logic [31:0]         INSTR_COUNT,
    output state_e              DBG_STATE
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [31:0] count_q;
    logic [31:0] next_pc_d;

    pc_target_calc #(
        .OFFSET_W (OFFSET_W)
    ) u_target (
        .pc_i       (pc_q),
        .offset_i   (OFFSET),
        .redirect_i (JUMP | BRANCH_TAKEN),
        .next_pc_o  (next_pc_d)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        instr_q <= IMEM_READDATA;
                        valid_q <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!STALL) begin
                        pc_q    <= next_pc_d;
                        valid_q <= 1'b0;
                        count_q <= count_q + 32'd1;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // The read request is gated by RESET so an aborted fetch is dropped at once.
    assign IMEM_READ    = (state_q == S_FETCH) && !RESET;
    assign IMEM_ADDRESS = pc_q;
    assign PC           = pc_q;
    assign INSTRUCTION  = instr_q;
    assign INSTR_VALID  = valid_q;
    assign INSTR_COUNT  = count_q;
    assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        w_rst = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic [7:0]  offset = 8'h00;
    logic        busy = 1'b0;

    logic        rd, w_rd;
    logic [31:0] addr, w_addr, rdata, w_rdata;
    logic [31:0] pc, w_pc, instr, w_instr, cnt, w_cnt;
    logic        valid, w_valid;
    state_e      st, w_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word at address A is A+1.
    assign rdata   = addr + 32'd1;
    assign w_rdata = w_addr + 32'd1;

    pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .OFFSET_W(8)) dut (
        .CLK(clk), .RESET(rst), .STALL(stall), .JUMP(jump),
        .BRANCH_TAKEN(branch), .OFFSET(offset), .IMEM_READDATA(rdata),
        .IMEM_BUSYWAIT(busy), .IMEM_READ(rd), .IMEM_ADDRESS(addr), .PC(pc),
        .INSTRUCTION(instr), .INSTR_VALID(valid), .INSTR_COUNT(cnt),
        .DBG_STATE(st)
    );

    pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .OFFSET_W(8)) dut_w (
        .CLK(clk), .RESET(w_rst), .STALL(stall), .JUMP(jump),
        .BRANCH_TAKEN(branch), .OFFSET(offset), .IMEM_READDATA(w_rdata),
        .IMEM_BUSYWAIT(busy), .IMEM_READ(w_rd), .IMEM_ADDRESS(w_addr), .PC(w_pc),
        .INSTRUCTION(w_instr), .INSTR_VALID(w_valid), .INSTR_COUNT(w_cnt),
        .DBG_STATE(w_st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch at the current PC with zero wait, then retire without redirect.
    task automatic seq_instr();
        step();
        step();
    endtask

    initial begin
        // ---- 1: reset + zero-wait fetch
        #1 rst = 1'b1;
        w_rst = 1'b1;
        #2;
        chk("rst_read", 32'(rd), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_count", cnt, 32'h0);
        step();
        rst = 1'b0;
        #1;
        chk("t1_read", 32'(rd), 32'd1);
        chk("t1_addr", addr, 32'h0);
        step();
        chk("t1_instr", instr, 32'h1);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_read_exec", 32'(rd), 32'd0);
        chk("t1_state", 32'(st), 32'(S_EXEC));
        step();
        chk("t1_pc", pc, 32'h4);
        chk("t1_count", cnt, 32'h1);
        chk("t1_valid_off", 32'(valid), 32'd0);
        seq_instr();
        chk("t1_pc8", pc, 32'h8);

        // ---- 2: busywait at PC=8
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_read", 32'(rd), 32'd1);
            chk("t2_instr", instr, 32'h5);
            chk("t2_valid", 32'(valid), 32'd0);
            chk("t2_pc", pc, 32'h8);
        end
        busy = 1'b0;
        step();
        chk("t2_capture", instr, 32'h9);
        chk("t2_valid_on", 32'(valid), 32'd1);
        step();
        seq_instr();
        chk("t2_pc16", pc, 32'h10);
        chk("t2_count", cnt, 32'd4);

        // ---- 3: branch / jump; redirect inputs are ignored in S_FETCH
        branch = 1'b1;
        offset = 8'hFE;
        step();
        chk("t3_fetch_ignore", pc, 32'h10);
        step();
        chk("t3_branch", pc, 32'hC);
        branch = 1'b0;
        seq_instr();
        chk("t3_back16", pc, 32'h10);
        step();
        jump = 1'b1;
        offset = 8'h03;
        step();
        chk("t3_jump", pc, 32'h20);
        offset = 8'hFB;
        seq_instr();
        chk("t3_neg_jump", pc, 32'h10);
        branch = 1'b1;
        offset = 8'h01;
        seq_instr();
        chk("t3_both", pc, 32'h18);
        branch = 1'b0;
        offset = 8'h03;
        seq_instr();
        chk("t3_to40", pc, 32'h28);
        jump = 1'b0;
        offset = 8'h00;
        chk("t3_count", cnt, 32'd10);

        // ---- 4: stall in S_EXEC at PC=40
        step();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_pc", pc, 32'h28);
            chk("t4_valid", 32'(valid), 32'd1);
            chk("t4_count", cnt, 32'd10);
            chk("t4_instr", instr, 32'h29);
        end
        stall = 1'b0;
        step();
        chk("t4_release_pc", pc, 32'h2C);
        chk("t4_release_cnt", cnt, 32'd11);

        // ---- 6: reset mid-fetch with busywait
        busy = 1'b1;
        step();
        chk("t6_pre_read", 32'(rd), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("t6_read", 32'(rd), 32'd0);
        chk("t6_pc", pc, 32'h0);
        chk("t6_instr", instr, 32'h0);
        chk("t6_count", cnt, 32'h0);
        step();
        rst = 1'b0;
        busy = 1'b0;
        #1;
        chk("t6_restart_read", 32'(rd), 32'd1);
        chk("t6_restart_addr", addr, 32'h0);
        step();
        chk("t6_restart_instr", instr, 32'h1);

        // ---- 5: wrap-around on the second instance
        w_rst = 1'b0;
        #1;
        chk("t5_start_pc", w_pc, 32'hFFFF_FFFC);
        chk("t5_start_read", 32'(w_rd), 32'd1);
        step();
        chk("t5_instr", w_instr, 32'hFFFF_FFFD);
        step();
        chk("t5_wrap", w_pc, 32'h0);
        step();
        branch = 1'b1;
        offset = 8'h80;
        step();
        chk("t5_neg_wrap", w_pc, 32'hFFFF_FE04);
        chk("t5_count", w_cnt, 32'd2);
        branch = 1'b0;
        offset = 8'h00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
